// File: rtl/mem_port_arbiter.sv
// Shares the core's single memory bus port between instruction fetch and the MEM stage.
// One transaction in flight at a time: IDLE -> REQ -> WAIT -> RESP, with a bounded MEM streak.
module mem_port_arbiter #(
   parameter int unsigned MAX_MEM_STREAK = 4,
   parameter int unsigned ADDR_W         = 64
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_done,
   output logic [31:0]       if_rdata,
   output logic              if_stall,

   input  logic              mem_req,
   input  logic              mem_wen,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [63:0]       mem_wdata,
   input  logic [7:0]        mem_mask,
   output logic              mem_done,
   output logic [63:0]       mem_rdata,
   output logic              mem_stall,

   output logic              bus_req,
   output logic              bus_wen,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [63:0]       bus_wdata,
   output logic [7:0]        bus_wmask,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [63:0]       bus_rdata
);

   localparam logic [3:0] MAX_STREAK = 4'(MAX_MEM_STREAK);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_e;

   typedef enum logic {
      OWN_IF,
      OWN_MEM
   } owner_e;

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [3:0]        streak_q, streak_d;
   logic              flush_q, flush_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [7:0]        wmask_q, wmask_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [63:0]       mem_rdata_q, mem_rdata_d;

   logic if_eligible;
   logic streak_full;
   logic grant_if;
   logic grant_mem;

   // A flush in IDLE only hides the fetch for that cycle; MEM wins ties until the streak is full.
   assign if_eligible = if_req & ~if_flush;
   assign streak_full = (streak_q == MAX_STREAK);
   assign grant_if    = (state_q == S_IDLE) & if_eligible & (~mem_req | streak_full);
   assign grant_mem   = (state_q == S_IDLE) & mem_req & ~(if_eligible & streak_full);

   always_comb begin
      // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
      state_d     = state_q;
      owner_d     = owner_q;
      streak_d    = streak_q;
      flush_d     = flush_q;
      addr_d      = addr_q;
      wen_d       = wen_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (grant_mem) begin
               state_d  = S_REQ;
               owner_d  = OWN_MEM;
               addr_d   = mem_addr;
               wen_d    = mem_wen;
               wdata_d  = mem_wdata;
               wmask_d  = mem_mask;
               streak_d = !if_req    ? 4'd0 :
                          streak_full ? streak_q : streak_q + 4'd1;
            end else if (grant_if) begin
               state_d  = S_REQ;
               owner_d  = OWN_IF;
               addr_d   = if_addr;
               wen_d    = 1'b0;
               wdata_d  = '0;
               wmask_d  = '0;
               streak_d = 4'd0;
            end else if (!if_req) begin
               streak_d = 4'd0;
            end
         end

         S_REQ: begin
            if (owner_q == OWN_IF && if_flush) flush_d = 1'b1;
            if (bus_gnt) state_d = S_WAIT;
         end

         S_WAIT: begin
            if (owner_q == OWN_IF && if_flush) flush_d = 1'b1;
            if (bus_rvalid) begin
               state_d = S_RESP;
               // A flushed fetch still finishes on the bus but must not disturb if_rdata.
               if (owner_q == OWN_MEM) begin
                  if (!wen_q) mem_rdata_d = bus_rdata;
               end else if (!(flush_q || if_flush)) begin
                  if_rdata_d = addr_q[2] ? bus_rdata[63:32] : bus_rdata[31:0];
               end
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
            flush_d = 1'b0;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_IF;
         streak_q    <= 4'd0;
         flush_q     <= 1'b0;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         // NOTE: non-blocking updates keep every register sampling the pre-edge values.
         state_q     <= state_d;
         owner_q     <= owner_d;
         streak_q    <= streak_d;
         flush_q     <= flush_d;
         addr_q      <= addr_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign bus_req   = (state_q == S_REQ);
   assign bus_wen   = wen_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_wmask = wmask_q;

   assign if_done   = (state_q == S_RESP) & (owner_q == OWN_IF) & ~flush_q;
   assign mem_done  = (state_q == S_RESP) & (owner_q == OWN_MEM);
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign if_stall  = if_req & ~if_done;
   assign mem_stall = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the requesters, the bus and a sparse backing memory.
module tb_mem_port_arbiter;

   localparam int unsigned ADDR_W         = 64;
   localparam int unsigned MAX_MEM_STREAK = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req, if_flush, if_done, if_stall;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              mem_req, mem_wen, mem_done, mem_stall;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata, mem_rdata;
   logic [7:0]        mem_mask;
   logic              bus_req, bus_wen, bus_gnt, bus_rvalid;
   logic [ADDR_W-1:0] bus_addr;
   logic [63:0]       bus_wdata, bus_rdata;
   logic [7:0]        bus_wmask;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_if_rdata;
   logic [63:0] exp_mem_rdata;
   logic [63:0] ram [logic [63:0]];

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_MEM_STREAK(MAX_MEM_STREAK), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_mask(mem_mask), .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
      .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wmask(bus_wmask), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      if_req = 0; if_addr = '0; if_flush = 0;
      mem_req = 0; mem_wen = 0; mem_addr = '0; mem_wdata = '0; mem_mask = '0;
      bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
   endtask

   function automatic logic [63:0] ram_rd(input logic [63:0] a);
      logic [63:0] k;
      k = {a[63:3], 3'b000};
      if (ram.exists(k)) return ram[k];
      return {~k[31:0], k[31:0] ^ 32'h5A5A_0F0F};
   endfunction

   task automatic test_reset;
      rst = 1'b0;
      clear_inputs();
      repeat (2) tick();
      total++; if ({bus_req, bus_wen, if_done, mem_done, bus_wmask} !== 12'h000) begin bad++; $display("FAIL reset_ctrl: got %h want 000", {bus_req, bus_wen, if_done, mem_done, bus_wmask}); end
      total++; if (bus_addr !== '0 || bus_wdata !== '0) begin bad++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0", bus_addr, bus_wdata); end
      total++; if (if_rdata !== 32'h0 || mem_rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata: got if=%h mem=%h want 0", if_rdata, mem_rdata); end
      exp_if_rdata  = '0;
      exp_mem_rdata = '0;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_fetch;
      if_req = 1; if_addr = 64'h8000_0004;
      tick();
      total++; if (bus_req !== 1'b1 || bus_addr !== 64'h8000_0004) begin bad++; $display("FAIL fetch_c1_req: got req=%0b addr=%h want 1 80000004", bus_req, bus_addr); end
      total++; if (bus_wen !== 1'b0 || bus_wmask !== 8'h00) begin bad++; $display("FAIL fetch_c1_wr: got wen=%0b mask=%h want 0 00", bus_wen, bus_wmask); end
      total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL fetch_c1_stall: got %0b want 1", if_stall); end
      bus_gnt = 1;
      tick();
      bus_gnt = 0;
      total++; if (bus_req !== 1'b0 || if_done !== 1'b0) begin bad++; $display("FAIL fetch_c2: got req=%0b done=%0b want 0 0", bus_req, if_done); end
      bus_rvalid = 1; bus_rdata = 64'h0010_0073_0000_0013;
      tick();
      bus_rvalid = 0;
      total++; if (if_done !== 1'b1 || mem_done !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL fetch_c3_done: got if=%0b mem=%0b req=%0b want 1 0 0", if_done, mem_done, bus_req); end
      total++; if (if_rdata !== 32'h0010_0073) begin bad++; $display("FAIL fetch_c3_data: got %h want 00100073", if_rdata); end
      total++; if (if_stall !== 1'b0) begin bad++; $display("FAIL fetch_c3_stall: got %0b want 0", if_stall); end
      exp_if_rdata = 32'h0010_0073;
      if_req = 0;
      tick();
      total++; if (if_done !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL fetch_c4: got done=%0b req=%0b want 0 0", if_done, bus_req); end
   endtask

   task automatic test_store;
      mem_req = 1; mem_wen = 1; mem_addr = 64'h8000_1000;
      mem_wdata = 64'h1122_3344_5566_7788; mem_mask = 8'h0F;
      tick();
      for (int k = 0; k < 3; k++) begin
         total++; if ({bus_req, bus_wen, bus_wmask} !== {1'b1, 1'b1, 8'h0F}) begin bad++; $display("FAIL store_req%0d_ctrl: got %h want 30f", k, {bus_req, bus_wen, bus_wmask}); end
         total++; if (bus_addr !== 64'h8000_1000 || bus_wdata !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL store_req%0d_fields: got %h %h", k, bus_addr, bus_wdata); end
         total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL store_req%0d_stall: got %0b want 1", k, mem_stall); end
         bus_gnt = (k == 2);
         tick();
      end
      bus_gnt = 0;
      total++; if (bus_req !== 1'b0 || mem_done !== 1'b0) begin bad++; $display("FAIL store_wait: got req=%0b done=%0b want 0 0", bus_req, mem_done); end
      bus_rvalid = 1; bus_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      tick();
      bus_rvalid = 0;
      total++; if (mem_done !== 1'b1 || mem_stall !== 1'b0 || if_done !== 1'b0) begin bad++; $display("FAIL store_done: got done=%0b stall=%0b if=%0b want 1 0 0", mem_done, mem_stall, if_done); end
      total++; if (mem_rdata !== exp_mem_rdata) begin bad++; $display("FAIL store_rdata_hold: got %h want %h", mem_rdata, exp_mem_rdata); end
      mem_req = 0; mem_wen = 0;
      tick();
      total++; if (mem_done !== 1'b0) begin bad++; $display("FAIL store_one_pulse: got %0b want 0", mem_done); end
   endtask

   task automatic test_fairness;
      bit owner_if [0:15];
      int n, if_cnt, mem_cnt;
      bit gnt_prev;
      n = 0; if_cnt = 0; mem_cnt = 0; gnt_prev = 0;
      if_req = 1; if_addr = 64'h8000_0000;
      mem_req = 1; mem_wen = 0; mem_addr = 64'h8000_2000; mem_mask = 8'hFF;
      bus_rdata = 64'hCAFE_0001_0BAD_0002;
      for (int c = 0; c < 40; c++) begin
         if (bus_req && n < 16) begin
            owner_if[n] = (bus_addr == 64'h8000_0000);
            n++;
         end
         if (if_done) if_cnt++;
         if (mem_done) mem_cnt++;
         bus_gnt    = bus_req;
         bus_rvalid = gnt_prev;
         gnt_prev   = bus_gnt;
         tick();
      end
      clear_inputs();
      total++; if (n !== 10) begin bad++; $display("FAIL fair_txn_count: got %0d want 10", n); end
      for (int i = 0; i < 10; i++) begin
         total++; if (owner_if[i] !== (i % 5 == 4)) begin bad++; $display("FAIL fair_order_%0d: got if=%0b want %0b", i, owner_if[i], (i % 5 == 4)); end
      end
      total++; if (if_cnt !== 2 || mem_cnt !== 8) begin bad++; $display("FAIL fair_done_count: got if=%0d mem=%0d want 2 8", if_cnt, mem_cnt); end
      exp_if_rdata  = 32'h0BAD_0002;
      exp_mem_rdata = 64'hCAFE_0001_0BAD_0002;
      total++; if (if_rdata !== exp_if_rdata || mem_rdata !== exp_mem_rdata) begin bad++; $display("FAIL fair_rdata: got %h %h", if_rdata, mem_rdata); end
      tick();
   endtask

   task automatic test_flush;
      if_req = 1; if_addr = 64'h8000_0008;
      tick();
      bus_gnt = 1;
      tick();
      bus_gnt = 0; bus_rvalid = 1; bus_rdata = 64'h1111_2222_3333_4444;
      tick();
      bus_rvalid = 0;
      exp_if_rdata = 32'h3333_4444;
      total++; if (if_done !== 1'b1 || if_rdata !== exp_if_rdata) begin bad++; $display("FAIL flush_pre: got done=%0b data=%h want 1 %h", if_done, if_rdata, exp_if_rdata); end
      if_req = 0;
      tick();
      if_req = 1; if_addr = 64'h8000_0010;
      tick();
      bus_gnt = 1;
      tick();
      bus_gnt = 0; if_flush = 1;
      tick();
      if_flush = 0; if_req = 0; bus_rvalid = 1; bus_rdata = 64'hDEAD_0000_BEEF_0000;
      tick();
      bus_rvalid = 0;
      total++; if (if_done !== 1'b0 || mem_done !== 1'b0) begin bad++; $display("FAIL flush_resp_done: got if=%0b mem=%0b want 0 0", if_done, mem_done); end
      total++; if (if_rdata !== exp_if_rdata) begin bad++; $display("FAIL flush_rdata_hold: got %h want %h", if_rdata, exp_if_rdata); end
      tick();
      if_req = 1; if_flush = 1; if_addr = 64'h8000_0014;
      tick();
      total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL flush_idle_block: got %0b want 0", bus_req); end
      if_flush = 0;
      tick();
      total++; if (bus_req !== 1'b1 || bus_addr !== 64'h8000_0014) begin bad++; $display("FAIL flush_next_req: got req=%0b addr=%h want 1 80000014", bus_req, bus_addr); end
      bus_gnt = 1;
      tick();
      bus_gnt = 0; bus_rvalid = 1; bus_rdata = 64'hABCD_0123_4567_89EF;
      tick();
      bus_rvalid = 0;
      exp_if_rdata = 32'hABCD_0123;
      total++; if (if_done !== 1'b1 || if_rdata !== exp_if_rdata) begin bad++; $display("FAIL flush_next_done: got done=%0b data=%h want 1 %h", if_done, if_rdata, exp_if_rdata); end
      if_req = 0;
      tick();
   endtask

   task automatic test_reset_midop;
      mem_req = 1; mem_wen = 0; mem_addr = 64'h8000_1008; mem_mask = 8'hFF;
      tick();
      bus_gnt = 1;
      tick();
      bus_gnt = 0;
      rst = 1'b0;
      #1;
      total++; if ({bus_req, if_done, mem_done} !== 3'b000) begin bad++; $display("FAIL rst_mid_ctrl: got %b want 000", {bus_req, if_done, mem_done}); end
      total++; if (bus_addr !== '0 || if_rdata !== '0 || mem_rdata !== '0) begin bad++; $display("FAIL rst_mid_regs: got %h %h %h want 0", bus_addr, if_rdata, mem_rdata); end
      exp_if_rdata = '0; exp_mem_rdata = '0;
      mem_req = 0;
      tick();
      rst = 1'b1;
      tick();
      bus_rvalid = 1; bus_rdata = 64'h5555_AAAA_5555_AAAA;
      tick();
      bus_rvalid = 0;
      total++; if (mem_done !== 1'b0 || if_done !== 1'b0 || mem_rdata !== exp_mem_rdata) begin bad++; $display("FAIL rst_stale_rvalid: got done=%0b/%0b data=%h", mem_done, if_done, mem_rdata); end
      mem_req = 1; mem_addr = 64'h8000_1010;
      tick();
      total++; if (bus_req !== 1'b1 || bus_addr !== 64'h8000_1010) begin bad++; $display("FAIL rst_new_req: got req=%0b addr=%h", bus_req, bus_addr); end
      bus_gnt = 1;
      tick();
      bus_gnt = 0; bus_rvalid = 1; bus_rdata = 64'h0123_4567_89AB_CDEF;
      tick();
      bus_rvalid = 0;
      exp_mem_rdata = 64'h0123_4567_89AB_CDEF;
      total++; if (mem_done !== 1'b1 || mem_rdata !== exp_mem_rdata) begin bad++; $display("FAIL rst_new_done: got done=%0b data=%h want 1 %h", mem_done, mem_rdata, exp_mem_rdata); end
      mem_req = 0;
      tick();
   endtask

   task automatic test_spurious_rvalid;
      int dones;
      dones = 0;
      mem_req = 1; mem_wen = 0; mem_addr = 64'h8000_1018; mem_mask = 8'hFF;
      tick();
      bus_rvalid = 1; bus_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      tick();
      bus_rvalid = 0;
      total++; if (bus_req !== 1'b1 || mem_done !== 1'b0) begin bad++; $display("FAIL spur_ignored: got req=%0b done=%0b want 1 0", bus_req, mem_done); end
      bus_gnt = 1;
      tick();
      bus_gnt = 0; bus_rvalid = 1; bus_rdata = 64'h7777_6666_5555_4444;
      exp_mem_rdata = 64'h7777_6666_5555_4444;
      tick();
      bus_rvalid = 0;
      mem_req = 0;
      for (int c = 0; c < 4; c++) begin
         if (mem_done) dones++;
         tick();
      end
      total++; if (dones !== 1) begin bad++; $display("FAIL spur_done_count: got %0d want 1", dones); end
      total++; if (mem_rdata !== exp_mem_rdata) begin bad++; $display("FAIL spur_rdata: got %h want %h", mem_rdata, exp_mem_rdata); end
   endtask

   task automatic test_random;
      bit          if_pend, mem_pend, rsp_busy, t_is_if, t_wen, exp_if_d, exp_mem_d;
      logic        m_w;
      logic [63:0] if_a, m_a, m_wd, t_addr, t_wdata, w;
      logic [7:0]  m_mask, t_mask;
      int          rsp_delay, if_age, mem_age, n_if, n_mem;
      if_pend = 0; mem_pend = 0; rsp_busy = 0; t_is_if = 0; t_wen = 0; exp_if_d = 0; exp_mem_d = 0;
      m_w = 0; if_a = 64'h8000_0000; m_a = 64'h8000_1000; m_wd = '0; t_addr = '0; t_wdata = '0;
      m_mask = '0; t_mask = '0; rsp_delay = 0; if_age = 0; mem_age = 0; n_if = 0; n_mem = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         total++; if (if_done !== exp_if_d) begin bad++; $display("FAIL rnd_if_done@%0d: got %0b want %0b", cyc, if_done, exp_if_d); end
         total++; if (mem_done !== exp_mem_d) begin bad++; $display("FAIL rnd_mem_done@%0d: got %0b want %0b", cyc, mem_done, exp_mem_d); end
         total++; if (if_rdata !== exp_if_rdata) begin bad++; $display("FAIL rnd_if_rdata@%0d: got %h want %h", cyc, if_rdata, exp_if_rdata); end
         total++; if (mem_rdata !== exp_mem_rdata) begin bad++; $display("FAIL rnd_mem_rdata@%0d: got %h want %h", cyc, mem_rdata, exp_mem_rdata); end
         if (exp_if_d) begin if_pend = 0; n_if++; end
         if (exp_mem_d) begin mem_pend = 0; n_mem++; end
         exp_if_d = 0; exp_mem_d = 0;

         if (bus_req) begin
            total++;
            if (!bus_addr[12]) begin
               if (!if_pend || bus_addr !== if_a || bus_wen !== 1'b0 || bus_wmask !== 8'h00) begin
                  bad++; $display("FAIL rnd_if_bus@%0d: got addr=%h wen=%0b mask=%h want addr=%h wen=0 mask=00 pend=%0b", cyc, bus_addr, bus_wen, bus_wmask, if_a, if_pend);
               end
            end else begin
               if (!mem_pend || bus_addr !== m_a || bus_wen !== m_w || bus_wmask !== m_mask || bus_wdata !== m_wd) begin
                  bad++; $display("FAIL rnd_mem_bus@%0d: got %h/%0b/%h/%h want %h/%0b/%h/%h pend=%0b", cyc, bus_addr, bus_wen, bus_wmask, bus_wdata, m_a, m_w, m_mask, m_wd, mem_pend);
               end
            end
         end

         bus_gnt = 0; bus_rvalid = 0; bus_rdata = {$urandom, $urandom};
         if (rsp_busy) begin
            if (rsp_delay == 0) begin
               rsp_busy = 0; bus_rvalid = 1;
               if (t_is_if) begin
                  w = ram_rd(t_addr); bus_rdata = w;
                  exp_if_rdata = t_addr[2] ? w[63:32] : w[31:0];
                  exp_if_d = 1;
               end else if (t_wen) begin
                  w = ram_rd(t_addr);
                  for (int b = 0; b < 8; b++) if (t_mask[b]) w[b*8 +: 8] = t_wdata[b*8 +: 8];
                  ram[{t_addr[63:3], 3'b000}] = w;
                  exp_mem_d = 1;
               end else begin
                  w = ram_rd(t_addr); bus_rdata = w;
                  exp_mem_rdata = w;
                  exp_mem_d = 1;
               end
            end else begin
               rsp_delay--;
            end
         end else if (bus_req && $urandom_range(0, 1) == 1) begin
            bus_gnt = 1; rsp_busy = 1; rsp_delay = $urandom_range(0, 2);
            t_is_if = !bus_addr[12];
            t_addr  = t_is_if ? if_a : m_a;
            t_wen   = t_is_if ? 1'b0 : m_w;
            t_wdata = m_wd; t_mask = m_mask;
         end else if ($urandom_range(0, 5) == 0) begin
            bus_rvalid = 1;
         end

         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1; if_age = 0;
            if_a = 64'h8000_0000 + 64'($urandom_range(0, 63)) * 4;
         end
         if (!mem_pend && $urandom_range(0, 2) == 0) begin
            mem_pend = 1; mem_age = 0;
            m_w = 1'($urandom_range(0, 1));
            m_a = 64'h8000_1000 + 64'($urandom_range(0, 15)) * 8;
            m_wd = {$urandom, $urandom};
            m_mask = 8'($urandom);
         end
         if_req = if_pend; if_addr = if_a;
         mem_req = mem_pend; mem_wen = m_w; mem_addr = m_a; mem_wdata = m_wd; mem_mask = m_mask;

         if (if_pend) if_age++;
         if (mem_pend) mem_age++;
         if (if_age == 200) begin total++; bad++; $display("FAIL rnd_if_timeout@%0d: got no done in 200 cycles want done", cyc); end
         if (mem_age == 200) begin total++; bad++; $display("FAIL rnd_mem_timeout@%0d: got no done in 200 cycles want done", cyc); end
         tick();
      end
      clear_inputs();
      total++; if (n_if == 0 || n_mem == 0) begin bad++; $display("FAIL rnd_progress: got if=%0d mem=%0d want both nonzero", n_if, n_mem); end
      repeat (8) tick();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      test_reset();
      test_single_fetch();
      test_store();
      test_fairness();
      test_flush();
      test_reset_midop();
      test_spurious_rvalid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish want finish within 2ms");
      $fatal(1);
   end

endmodule
